// File: rtl/cache_controller.sv
// Direct-mapped, read-allocate, write-through / no-write-allocate data cache
// between the CPU data port and a DataMemory with a 4-word block read port.
module cache_controller #(
  parameter int WORD        = 32,
  parameter int ADDRESSL    = 15,
  parameter int BLOCKSIZE   = 4,
  parameter int INDEXL      = 10,
  parameter int MISS_CYCLES = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cpu_req,
  input  logic                cpu_we,
  input  logic [ADDRESSL-1:0] cpu_addr,
  input  logic [WORD-1:0]     cpu_wdata,
  output logic [WORD-1:0]     cpu_rdata,
  output logic                cpu_ready,
  output logic                mem_read,
  output logic                mem_write,
  output logic [ADDRESSL-1:0] mem_address,
  output logic [ADDRESSL-1:0] mem_address0,
  output logic [ADDRESSL-1:0] mem_address1,
  output logic [ADDRESSL-1:0] mem_address2,
  output logic [ADDRESSL-1:0] mem_address3,
  output logic [WORD-1:0]     mem_write_data,
  input  logic [WORD-1:0]     mem_block0,
  input  logic [WORD-1:0]     mem_block1,
  input  logic [WORD-1:0]     mem_block2,
  input  logic [WORD-1:0]     mem_block3,
  output logic [31:0]         hit_count,
  output logic [31:0]         access_count
);

  localparam int OFFL  = $clog2(BLOCKSIZE);
  localparam int TAGL  = ADDRESSL - INDEXL - OFFL;
  localparam int LINES = 1 << INDEXL;
  localparam int CW    = (MISS_CYCLES > 1) ? $clog2(MISS_CYCLES) : 1;

  typedef enum logic {IDLE, FETCH} state_e;

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [TAGL-1:0]     ftag_q, ftag_d;
  logic [INDEXL-1:0]   fidx_q, fidx_d;
  logic                replay_q, replay_d;
  logic [31:0]         hit_q, hit_d;
  logic [31:0]         acc_q, acc_d;

  logic [LINES-1:0]    valid_q;
  logic [TAGL-1:0]     tag_q  [LINES];
  logic [WORD-1:0]     data_q [LINES][BLOCKSIZE];

  logic [TAGL-1:0]     req_tag;
  logic [INDEXL-1:0]   req_idx;
  logic [OFFL-1:0]     req_off;
  logic                hit;
  logic                fill;
  logic                st_hit;

  assign req_tag = cpu_addr[ADDRESSL-1 -: TAGL];
  assign req_idx = cpu_addr[OFFL +: INDEXL];
  assign req_off = cpu_addr[OFFL-1:0];
  assign hit     = valid_q[req_idx] && (tag_q[req_idx] == req_tag);

  assign cpu_rdata      = data_q[req_idx][req_off];
  assign mem_address    = cpu_addr;
  assign mem_write_data = cpu_wdata;
  assign mem_address0   = {ftag_q, fidx_q, OFFL'(0)};
  assign mem_address1   = {ftag_q, fidx_q, OFFL'(1)};
  assign mem_address2   = {ftag_q, fidx_q, OFFL'(2)};
  assign mem_address3   = {ftag_q, fidx_q, OFFL'(3)};
  assign hit_count      = hit_q;
  assign access_count   = acc_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ftag_d    = ftag_q;
    fidx_d    = fidx_q;
    replay_d  = replay_q;
    hit_d     = hit_q;
    acc_d     = acc_q;
    fill      = 1'b0;
    st_hit    = 1'b0;
    cpu_ready = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    case (state_q)
      IDLE: begin
        if (cpu_req) begin
          if (cpu_we) begin
            cpu_ready = 1'b1;
            mem_write = 1'b1;
            st_hit    = hit;
          end else if (hit) begin
            cpu_ready = 1'b1;
            replay_d  = 1'b0;
            // The hit that replays a just-filled miss was already counted.
            if (!replay_q) begin
              hit_d = hit_q + 32'd1;
              acc_d = acc_q + 32'd1;
            end
          end else begin
            replay_d = 1'b0;
            acc_d    = acc_q + 32'd1;
            ftag_d   = req_tag;
            fidx_d   = req_idx;
            cnt_d    = CW'(MISS_CYCLES - 1);
            state_d  = FETCH;
          end
        end
      end
      FETCH: begin
        mem_read = 1'b1;
        if (cnt_q == '0) begin
          fill     = 1'b1;
          replay_d = 1'b1;
          state_d  = IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      ftag_q   <= '0;
      fidx_q   <= '0;
      replay_q <= 1'b0;
      hit_q    <= '0;
      acc_q    <= '0;
      valid_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ftag_q   <= ftag_d;
      fidx_q   <= fidx_d;
      replay_q <= replay_d;
      hit_q    <= hit_d;
      acc_q    <= acc_d;
      if (fill) valid_q[fidx_q] <= 1'b1;
    end
  end

  // Tag and data arrays carry no reset; valid_q alone qualifies them.
  always_ff @(posedge clk) begin
    if (fill) begin
      tag_q[fidx_q]     <= ftag_q;
      data_q[fidx_q][0] <= mem_block0;
      data_q[fidx_q][1] <= mem_block1;
      data_q[fidx_q][2] <= mem_block2;
      data_q[fidx_q][3] <= mem_block3;
    end else if (st_hit) begin
      data_q[req_idx][req_off] <= cpu_wdata;
    end
  end

endmodule

// File: tb/tb_cache_controller.sv
// Bench for cache_controller: directed table, hand-written corner sequences and
// randomized accesses checked against a transaction-level cache/memory model.
module tb_cache_controller;

  localparam int MISS = 4;

  logic        clk, rst;
  logic        cpu_req, cpu_we;
  logic [14:0] cpu_addr;
  logic [31:0] cpu_wdata, cpu_rdata;
  logic        cpu_ready, mem_read, mem_write;
  logic [14:0] mem_address, mem_address0, mem_address1, mem_address2, mem_address3;
  logic [31:0] mem_write_data, mem_block0, mem_block1, mem_block2, mem_block3;
  logic [31:0] hit_count, access_count;

  cache_controller #(.WORD(32), .ADDRESSL(15), .BLOCKSIZE(4), .INDEXL(10), .MISS_CYCLES(MISS)) dut (
    .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_address0(mem_address0), .mem_address1(mem_address1),
    .mem_address2(mem_address2), .mem_address3(mem_address3),
    .mem_write_data(mem_write_data), .mem_block0(mem_block0), .mem_block1(mem_block1),
    .mem_block2(mem_block2), .mem_block3(mem_block3),
    .hit_count(hit_count), .access_count(access_count));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] finit(input logic [14:0] a);
    return {17'd0, a} * 32'h9E3779B1 + 32'h01234567;
  endfunction

  // DataMemory stand-in
  logic [31:0] mem [32768];
  initial for (int i = 0; i < 32768; i++) mem[i] <= finit(15'(i));
  always @(posedge clk) if (mem_write) mem[mem_address] <= mem_write_data;
  assign mem_block0 = mem[mem_address0];
  assign mem_block1 = mem[mem_address1];
  assign mem_block2 = mem[mem_address2];
  assign mem_block3 = mem[mem_address3];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model: which lines hold which tag, plus the memory image.
  bit          m_valid [1024];
  logic [2:0]  m_tag   [1024];
  logic [31:0] g_wr    [int];
  int          m_hits, m_acc;
  bit          m_replay;

  function automatic logic [31:0] gread(input logic [14:0] a);
    return g_wr.exists(int'(a)) ? g_wr[int'(a)] : finit(a);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 1024; i++) m_valid[i] = 1'b0;
    m_hits = 0; m_acc = 0; m_replay = 1'b0;
  endtask

  task automatic model_access(input bit we, input logic [14:0] a, input logic [31:0] wd,
                              output int est, output logic [31:0] ed);
    int idx;
    bit h;
    idx = int'(a) / 4 % 1024;
    h   = m_valid[idx] && m_tag[idx] == a[14:12];
    est = 0;
    ed  = gread(a);
    if (we) g_wr[int'(a)] = wd;
    else if (h) begin
      if (!m_replay) begin m_hits++; m_acc++; end
      m_replay = 1'b0;
    end else begin
      est = MISS + 1;
      m_acc++;
      m_valid[idx] = 1'b1;
      m_tag[idx]   = a[14:12];
      m_replay     = 1'b0;
    end
  endtask

  // One CPU access, held until cpu_ready; reports what the DUT did.
  task automatic do_access(input bit we, input logic [14:0] a, input logic [31:0] wd,
                           output int stalls, output logic [31:0] rd,
                           output int nread, output int nwrite);
    bit done;
    logic [14:0] base;
    base = {a[14:2], 2'b00};
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = wd;
    stalls = 0; nread = 0; nwrite = 0; rd = '0; done = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      chk("rw_exclusive", {31'd0, mem_read & mem_write}, 32'd0);
      if (mem_read) begin
        nread++;
        if (nread == 1) begin
          chk("blk_addr0", {17'd0, mem_address0}, {17'd0, base});
          chk("blk_addr3", {17'd0, mem_address3}, {17'd0, base} + 32'd3);
        end
      end
      if (mem_write) nwrite++;
      if (cpu_ready) begin
        rd = cpu_rdata;
        if (we) begin
          chk("st_addr", {17'd0, mem_address}, {17'd0, a});
          chk("st_data", mem_write_data, wd);
        end
        done = 1'b1;
      end else stalls++;
      @(posedge clk); #1;
    end
    if (!done) chk("ready_timeout", 32'd0, 32'd1);
    cpu_req = 1'b0;
  endtask

  typedef struct {
    bit          we;
    logic [14:0] addr;
    logic [31:0] wdata;
    int          stalls;
    bit          chkd;
    logic [31:0] rdata;
    int          hits;
    int          acc;
  } vec_t;

  vec_t tbl [10];

  initial begin
    int st, nr, nw, est;
    logic [31:0] rd, ed;
    logic [14:0] a;
    bit we;
    logic [31:0] wd;

    tbl[0] = '{1'b0, 15'h0005, 32'h0,        MISS+1, 1'b1, finit(15'h0005), 0, 1};
    tbl[1] = '{1'b0, 15'h0004, 32'h0,        0,      1'b1, finit(15'h0004), 1, 2};
    tbl[2] = '{1'b0, 15'h0006, 32'h0,        0,      1'b1, finit(15'h0006), 2, 3};
    tbl[3] = '{1'b0, 15'h0007, 32'h0,        0,      1'b1, finit(15'h0007), 3, 4};
    tbl[4] = '{1'b0, 15'h1004, 32'h0,        MISS+1, 1'b1, finit(15'h1004), 3, 5};
    tbl[5] = '{1'b0, 15'h0004, 32'h0,        MISS+1, 1'b1, finit(15'h0004), 3, 6};
    tbl[6] = '{1'b1, 15'h0005, 32'hDEADBEEF, 0,      1'b0, 32'h0,           3, 6};
    tbl[7] = '{1'b0, 15'h0005, 32'h0,        0,      1'b1, 32'hDEADBEEF,    4, 7};
    tbl[8] = '{1'b1, 15'h2000, 32'h12345678, 0,      1'b0, 32'h0,           4, 7};
    tbl[9] = '{1'b0, 15'h2000, 32'h0,        MISS+1, 1'b1, 32'h12345678,    4, 8};

    rst = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", {31'd0, cpu_ready}, 32'd0);
    chk("rst_mem_read", {31'd0, mem_read}, 32'd0);
    chk("rst_mem_write", {31'd0, mem_write}, 32'd0);
    chk("rst_hits", hit_count, 32'd0);
    chk("rst_acc", access_count, 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Directed table
    for (int i = 0; i < 10; i++) begin
      model_access(tbl[i].we, tbl[i].addr, tbl[i].wdata, est, ed);
      do_access(tbl[i].we, tbl[i].addr, tbl[i].wdata, st, rd, nr, nw);
      chk("tbl_stalls", st, tbl[i].stalls);
      chk("tbl_reads", nr, (tbl[i].stalls > 0) ? MISS : 0);
      chk("tbl_writes", nw, {31'd0, tbl[i].we});
      if (tbl[i].chkd) chk("tbl_rdata", rd, tbl[i].rdata);
      chk("tbl_hits", hit_count, tbl[i].hits);
      chk("tbl_acc", access_count, tbl[i].acc);
    end
    chk("mem_store_hit", mem[5], 32'hDEADBEEF);
    chk("mem_store_miss", mem[15'h2000], 32'h12345678);

    // Request dropped mid-fetch: line still fills, the later hit is a replay.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 15'h1010;
    @(posedge clk); #1;
    @(posedge clk); #1;
    cpu_req = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("drop_ready_low", {31'd0, cpu_ready}, 32'd0);
    chk("drop_read_done", {31'd0, mem_read}, 32'd0);
    @(posedge clk); #1;
    model_access(1'b0, 15'h1010, 32'h0, est, ed);
    m_replay = 1'b1;
    for (int k = 0; k < 2; k++) begin
      a = 15'h1010 + 15'(k);
      model_access(1'b0, a, 32'h0, est, ed);
      do_access(1'b0, a, 32'h0, st, rd, nr, nw);
      chk("drop_stalls", st, est);
      chk("drop_rdata", rd, ed);
      chk("drop_hits", hit_count, m_hits);
      chk("drop_acc", access_count, m_acc);
    end

    // Reset on the second fetch cycle aborts the fill.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 15'h3008;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("fetch_active", {31'd0, mem_read}, 32'd1);
    rst = 1'b0;
    #1;
    chk("abort_mem_read", {31'd0, mem_read}, 32'd0);
    chk("abort_hits", hit_count, 32'd0);
    chk("abort_acc", access_count, 32'd0);
    cpu_req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    model_reset();
    for (int k = 0; k < 2; k++) begin
      a = (k == 0) ? 15'h3008 : 15'h0005;
      model_access(1'b0, a, 32'h0, est, ed);
      do_access(1'b0, a, 32'h0, st, rd, nr, nw);
      chk("post_rst_stalls", st, MISS + 1);
      chk("post_rst_rdata", rd, ed);
      chk("post_rst_acc", access_count, m_acc);
    end

    // Randomized traffic over a few indices so hits, conflicts and stores mix.
    for (int n = 0; n < 250; n++) begin
      we = ($urandom_range(0, 3) == 0);
      a  = {3'($urandom_range(0, 7)), 10'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
      wd = $urandom;
      if ($urandom_range(0, 4) == 0) begin
        @(negedge clk);
        chk("idle_ready", {31'd0, cpu_ready}, 32'd0);
        @(posedge clk); #1;
      end
      model_access(we, a, wd, est, ed);
      do_access(we, a, wd, st, rd, nr, nw);
      chk("rnd_stalls", st, est);
      chk("rnd_reads", nr, (est > 0) ? MISS : 0);
      chk("rnd_writes", nw, {31'd0, we});
      if (!we) chk("rnd_rdata", rd, ed);
      chk("rnd_hits", hit_count, m_hits);
      chk("rnd_acc", access_count, m_acc);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cache_controller.md
Name: cache_controller

Overview:
- Direct-mapped, read-allocate, write-through/no-write-allocate cache between the CPU data port and DataMemory.
- Serves CPU loads from a local data array.
- On a miss, fetches a 4-word block from DataMemory through its block read port (address0..address3/block), modelling a fixed miss penalty.
- Forwards every store to DataMemory and keeps hit/access statistics.

Parameters:
WORD, 32, data word width
ADDRESSL, 15, word-address width (matches DataMemory)
BLOCKSIZE, 4, words per block (fixed at 4; offset = 2 bits)
INDEXL, 10, index width (1024 lines); tag width = ADDRESSL-INDEXL-2 = 3
MISS_CYCLES, 4, memory wait cycles per block fetch (>=1)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  reset, asynchronous, active-low
cpu_req  input  1  CPU access request valid
cpu_we  input  1  1 = store, 0 = load
cpu_addr  input  ADDRESSL  CPU word address {tag,index,offset}
cpu_wdata  input  WORD  store data
cpu_rdata  output  WORD  load data, valid when cpu_ready=1 and load
cpu_ready  output  1  access completes this cycle; 0 = CPU must stall and hold inputs
mem_read  output  1  to DataMemory memRead
mem_write  output  1  to DataMemory memWrite
mem_address  output  ADDRESSL  to DataMemory address (store target)
mem_address0..mem_address3  output  ADDRESSL each  block word addresses {tag,index,2'd0..2'd3}
mem_write_data  output  WORD  to DataMemory writeData
mem_block0..mem_block3  input  WORD each  block words from DataMemory
hit_count  output  32  completed load hits
access_count  output  32  total loads accepted

Behaviour:
- Arrays: valid[1024] (flops, reset-cleared), tag[1024] x3, data[1024] x 4 x WORD (not reset).
- hit = valid[index] && tag[index]==cpu_addr tag.
- FSM states: IDLE, FETCH.
- Reset (rst=0, async): state=IDLE, all valid=0, counters=0, mem_read=0, mem_write=0, replay=0, wait counter=0.
- cpu_ready=0 whenever cpu_req=0 (cpu_rdata don't-care).
- IDLE, load, hit:
  - cpu_ready=1 same cycle; cpu_rdata=data[index][offset] (combinational).
  - Counters: hit_count+1, access_count+1 unless replay=1; replay cleared.
- IDLE, load, miss:
  - cpu_ready=0; access_count+1; next state FETCH.
  - Load tag/index; wait counter=MISS_CYCLES-1.
- FETCH:
  - mem_read=1; mem_address0..3 = {latched tag,index,k}; cpu_ready=0; counter decrements each cycle.
  - On the cycle counter==0, at the clock edge: write mem_block0..3 into data[index][0..3], set tag, valid=1, replay=1, state=IDLE.
  - Following IDLE cycle hits; with replay set, that hit does not count.
  - Miss latency: MISS_CYCLES stall cycles in FETCH plus 1 stall cycle in IDLE (miss detect); data returned on cycle MISS_CYCLES+1 after request.
- IDLE, store:
  - cpu_ready=1 same cycle; mem_write=1, mem_address=cpu_addr, mem_write_data=cpu_wdata (combinational, written at edge by DataMemory).
  - If hit, data[index][offset]<=cpu_wdata at same edge. Miss: no allocate, valid/tag unchanged.
  - Stores not counted.
- mem_read=0 and mem_write=0 outside these cases; mem_read and mem_write never both 1.
- Conflict miss overwrites line unconditionally (no dirty state; write-through).
- cpu_req dropped during FETCH: fetch still completes and fills line; replay cleared on next accepted load.
- Reset mid-FETCH: fetch aborted, line not filled, counters zero.
- Counters wrap modulo 2^32.

Test Plan:
- Cold load: after reset, load 0x0005 -> cpu_ready low for 5 cycles (MISS_CYCLES=4), mem_read high 4 cycles with mem_address0..3=0x0004..0x0007; cpu_rdata=memory[0x0005]; access_count=1, hit_count=0.
- Spatial hits: then loads 0x0004, 0x0006, 0x0007 -> each ready same cycle, correct data, no mem_read; hit_count=3, access_count=4.
- Conflict: load 0x1004 (same index, tag 1) -> miss/fill; then load 0x0004 -> miss again; valid line holds tag 0.
- Store hit: line 0x0004 cached, store 0xDEADBEEF to 0x0005 -> mem_write=1 one cycle, ready same cycle; subsequent load 0x0005 hits returning 0xDEADBEEF, memory also updated.
- Store miss: store 0x12345678 to 0x2000 (not cached) -> mem_write pulse; next load 0x2000 misses and fills with 0x12345678.
- Reset during FETCH: assert rst=0 on 2nd FETCH cycle -> mem_read drops immediately, counters 0; load same address afterwards misses again.
